adam_mem_pause_seq: RTL and testbench
=====================================

// Module: adam_mem_pause_seq
// PURPOSE
//  Sequences the four-phase pause handshake and soft resets of the NO_MEMS memory
//  slaves (bootloader ROM, AXI-Lite RAMs) on the FPGA top level. Sits between the
//  adam core mem_srst/mem_pause_* bundle and the memory instances. Pauses memories
//  in ascending index order and resumes them in descending order. Soft resets one
//  memory at a time: pause, reset, resume.
// PARAMETERS
//  NO_MEMS      3     number of memory slaves sequenced (1..16)
//  SRST_CYCLES  16    cycles mem_rst[i] is held for a soft reset (>=1)
//  TIMEOUT      1024  ack wait limit in cycles (used only with the macro)
// PORTS
//  clk            in   1        single clock for all logic
//  rst            in   1        synchronous, active-high reset
//  pause_req      in   1        global pause request (four-phase)
//  pause_ack      out  1        all memories paused
//  srst_req       in   NO_MEMS  per-memory soft-reset request pulse/level
//  mem_pause_req  out  NO_MEMS  pause request to memory i
//  mem_pause_ack  in   NO_MEMS  pause ack from memory i
//  mem_rst        out  NO_MEMS  reset to memory i (active-high, sync)
//  busy           out  1        sequencer not in RUN or PAUSED
//  timeout_err    out  NO_MEMS  sticky per-memory ack timeout flag
// BEHAVIOUR
//  - Reset values: pause_ack=0, mem_pause_req='0, mem_rst='1, busy=1, timeout_err='0,
//    pending='0, state=INIT. All outputs are registered.
//  - INIT: first cycle with rst=0 clears mem_rst to '0 and moves to RUN. busy drops
//    in the same cycle.
//  - Four-phase rule, global and per memory: req rises, then ack rises, then req
//    falls, then ack falls. A new req rises only after ack is 0.
//  - srst_req[i] high in any cycle sets pending[i]. pending is sticky until that
//    memory's soft reset finishes.
//  - RUN:
//    - pause_req=1 -> PAUSING with idx=0. This has priority over pending.
//    - Otherwise pending!=0 -> SR_PAUSE with idx=lowest set bit.
//  - PAUSING:
//    - Hold mem_pause_req[idx]=1. On mem_pause_ack[idx]=1: if idx=NO_MEMS-1 go to
//      PAUSED, else idx++.
//    - If pause_req is already 0 when the last ack arrives, go to RESUMING.
//      pause_ack is never raised in that case.
//  - PAUSED: pause_ack=1, set the cycle after the last ack. On pause_req=0: clear
//    pause_ack and go to RESUMING with idx=NO_MEMS-1.
//  - RESUMING:
//    - Clear mem_pause_req[idx]. Wait for mem_pause_ack[idx]=0.
//    - idx=0 -> RUN. Otherwise idx-- and repeat.
//  - SR_PAUSE: mem_pause_req[idx]=1. On ack go to SR_HOLD and load cnt=SRST_CYCLES-1.
//  - SR_HOLD: mem_rst[idx]=1, count down. At cnt=0: mem_rst[idx]=0, clear
//    pending[idx], go to SR_RESUME.
//  - SR_RESUME: mem_pause_req[idx]=0. On ack=0 -> RUN. pause_req arriving mid soft
//    reset is serviced from RUN afterwards.
//  - Latency, with memories that ack one cycle after req:
//    - pause_ack rises 2*NO_MEMS+1 cycles after pause_req rises.
//    - mem_rst pulse is exactly SRST_CYCLES cycles wide.
//  - Only one memory has req or rst changing at a time. Other mem_pause_req bits
//    hold their values.
//  - rst mid-sequence: immediate return to reset values regardless of state.
//    pending requests are discarded.
//  - Memories whose ack is already at the target level advance in 1 cycle each.
// CONFIGURATION
//  ADAM_PAUSE_SEQ_TIMEOUT_EN defined:
//   - A counter runs in every ack-wait state. After TIMEOUT cycles without the
//     expected ack level, timeout_err[idx] is set and the step counts as done.
//   - timeout_err clears only on rst.
//  ADAM_PAUSE_SEQ_TIMEOUT_EN undefined:
//   - No counter. Ack waits are unbounded. timeout_err tied '0.
// TESTING
//  1. rst 3 cycles then 0 -> mem_rst='1 during rst; mem_rst=000, busy=0 one cycle
//     later.
//  2. pause_req=1, 1-cycle ack memories -> mem_pause_req goes 001,011,111;
//     pause_ack=1 seven cycles after pause_req. pause_req=0 -> reqs 011,001,000,
//     then pause_ack=0 and busy=0.
//  3. srst_req=3'b110 one-cycle pulse -> mem 1 paused, mem_rst[1] high 16 cycles,
//     resumed; then the same for mem 2. mem 0 is never touched.
//  4. srst_req[0] and pause_req in the same RUN cycle -> global pause completes
//     first; after release, mem 0 soft reset runs.
//  5. rst asserted in SR_HOLD, cnt=5 -> next cycle mem_rst='1, mem_pause_req='0,
//     pending cleared.
//  6. Macro on, TIMEOUT=8, mem 1 never acks -> after 8 cycles timeout_err=3'b010,
//     sequencing continues; pause_ack still asserts.

Source files
------------

// File: rtl/adam_mem_pause_seq.sv
// adam_mem_pause_seq
// Pause/soft-reset sequencer for the NO_MEMS memory slaves on the FPGA top level.
// Global pause walks the memories in ascending index order and resumes them in
// descending order. Each memory uses a four-phase req/ack handshake. A soft reset
// handles one memory at a time: pause it, hold mem_rst, then resume it.
// Optional feature macro: ADAM_PAUSE_SEQ_TIMEOUT_EN. When it is defined, ack waits
// are bounded by TIMEOUT cycles and set a sticky timeout_err bit. When it is not
// defined, ack waits have no bound and timeout_err is tied low.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_INIT      | just out of reset, all memories held in mem_rst
// S_RUN       | idle, all memories running
// S_PAUSING   | raising mem_pause_req[idx] in ascending order
// S_PAUSED    | all memories paused, pause_ack high
// S_RESUMING  | dropping mem_pause_req[idx] in descending order
// S_SR_PAUSE  | pausing memory idx before its soft reset
// S_SR_HOLD   | mem_rst[idx] high, cnt counting down
// S_SR_RESUME | releasing memory idx after its soft reset

module adam_mem_pause_seq #(
    parameter int NO_MEMS     = 3,
    parameter int SRST_CYCLES = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_req,
    output logic               pause_ack,
    input  logic [NO_MEMS-1:0] srst_req,
    output logic [NO_MEMS-1:0] mem_pause_req,
    input  logic [NO_MEMS-1:0] mem_pause_ack,
    output logic [NO_MEMS-1:0] mem_rst,
    output logic               busy,
    output logic [NO_MEMS-1:0] timeout_err
);

    localparam int IW = (NO_MEMS > 1) ? $clog2(NO_MEMS) : 1;
    localparam int CW = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NO_MEMS - 1);

    // Stop elaboration on parameter values that the sequencer cannot handle.
    if (NO_MEMS < 1 || NO_MEMS > 16) begin : g_bad_no_mems
        $error("adam_mem_pause_seq: NO_MEMS must be 1..16");
    end
    if (SRST_CYCLES < 1) begin : g_bad_srst_cycles
        $error("adam_mem_pause_seq: SRST_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adam_mem_pause_seq: TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_PAUSING,
        S_PAUSED,
        S_RESUMING,
        S_SR_PAUSE,
        S_SR_HOLD,
        S_SR_RESUME
    } state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      idx, idx_nxt, idx_inc, idx_dec, idx_low;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NO_MEMS-1:0] pending, pending_nxt;
    logic [NO_MEMS-1:0] req_nxt, rst_nxt;
    logic               pause_ack_nxt, busy_nxt;
    logic               ack_cur, step_hi, step_lo;

    assign ack_cur = mem_pause_ack[idx];
    assign idx_inc = idx + 1'b1;
    assign idx_dec = idx - 1'b1;

    // Lowest pending soft-reset index: the lowest index is served first.
    always_comb begin
        idx_low = '0;
        for (int i = NO_MEMS - 1; i >= 0; i--) begin
            if (pending[i]) idx_low = IW'(i);
        end
    end

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt;
    logic          wait_st, want_hi, ack_met, tmo;

    // Detect an expired ack wait. A timed-out wait counts as a completed step.
    always_comb begin
        wait_st = (state == S_PAUSING) || (state == S_SR_PAUSE) ||
                  (state == S_RESUMING) || (state == S_SR_RESUME);
        want_hi = (state == S_PAUSING) || (state == S_SR_PAUSE);
        ack_met = want_hi ? ack_cur : !ack_cur;
        tmo     = wait_st && !ack_met && (tcnt == '0);
    end

    assign step_hi = ack_cur || tmo;
    assign step_lo = !ack_cur || tmo;

    // Down-counter reloaded at every step boundary; sticky per-memory error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= TW'(TIMEOUT - 1);
            timeout_err <= '0;
        end else begin
            if (!wait_st || ack_met || tmo) tcnt <= TW'(TIMEOUT - 1);
            else                            tcnt <= tcnt - 1'b1;
            if (tmo) timeout_err[idx] <= 1'b1;
        end
    end
`else
    assign step_hi     = ack_cur;
    assign step_lo     = !ack_cur;
    assign timeout_err = '0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_INIT;
            idx           <= '0;
            cnt           <= '0;
            pending       <= '0;
            pause_ack     <= 1'b0;
            mem_pause_req <= '0;
            mem_rst       <= '1;
            busy          <= 1'b1;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            cnt           <= cnt_nxt;
            pending       <= pending_nxt;
            pause_ack     <= pause_ack_nxt;
            mem_pause_req <= req_nxt;
            mem_rst       <= rst_nxt;
            busy          <= busy_nxt;
        end
    end

    // Next state and next output values. Only one memory changes its req or rst per step.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        pending_nxt   = pending | srst_req;
        pause_ack_nxt = pause_ack;
        req_nxt       = mem_pause_req;
        rst_nxt       = mem_rst;

        case (state)
            S_INIT: begin
                rst_nxt   = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (pause_req) begin
                    state_nxt  = S_PAUSING;
                    idx_nxt    = '0;
                    req_nxt[0] = 1'b1;
                end else if (|pending) begin
                    state_nxt        = S_SR_PAUSE;
                    idx_nxt          = idx_low;
                    req_nxt[idx_low] = 1'b1;
                end
            end
            S_PAUSING: begin
                if (step_hi) begin
                    if (idx == LAST) begin
                        if (pause_req) begin
                            state_nxt     = S_PAUSED;
                            pause_ack_nxt = 1'b1;
                        end else begin
                            // Request already withdrawn: skip PAUSED, never raise pause_ack.
                            state_nxt    = S_RESUMING;
                            req_nxt[idx] = 1'b0;
                        end
                    end else begin
                        idx_nxt          = idx_inc;
                        req_nxt[idx_inc] = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (!pause_req) begin
                    pause_ack_nxt = 1'b0;
                    state_nxt     = S_RESUMING;
                    idx_nxt       = LAST;
                    req_nxt[LAST] = 1'b0;
                end
            end
            S_RESUMING: begin
                if (step_lo) begin
                    if (idx == '0) begin
                        state_nxt = S_RUN;
                    end else begin
                        idx_nxt          = idx_dec;
                        req_nxt[idx_dec] = 1'b0;
                    end
                end
            end
            S_SR_PAUSE: begin
                if (step_hi) begin
                    state_nxt    = S_SR_HOLD;
                    cnt_nxt      = CW'(SRST_CYCLES - 1);
                    rst_nxt[idx] = 1'b1;
                end
            end
            S_SR_HOLD: begin
                if (cnt == '0) begin
                    rst_nxt[idx]     = 1'b0;
                    req_nxt[idx]     = 1'b0;
                    // A request arriving on the final cycle is kept for another round.
                    pending_nxt[idx] = srst_req[idx];
                    state_nxt        = S_SR_RESUME;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_SR_RESUME: begin
                if (step_lo) state_nxt = S_RUN;
            end
            default: state_nxt = S_INIT;
        endcase

        busy_nxt = !((state_nxt == S_RUN) || (state_nxt == S_PAUSED));
    end

endmodule

// File: tb/tb_adam_mem_pause_seq.sv
// Bench for adam_mem_pause_seq: 3 memories, 16-cycle soft reset, TIMEOUT=8.
// A scoreboard holds the expected mem_pause_req transitions and mem_rst pulses.
// Each test queues what it expects before it drives stimulus. A negedge monitor
// removes entries from the scoreboard as the DUT produces them.
module tb_adam_mem_pause_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_req = 1'b0;
    logic       pause_ack;
    logic [2:0] srst_req = 3'b000;
    logic [2:0] mem_pause_req;
    logic [2:0] mem_pause_ack;
    logic [2:0] mem_rst;
    logic       busy;
    logic [2:0] timeout_err;
    logic [2:0] stuck = 3'b000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int idx;
        int width;
    } rst_ev_t;

    logic [2:0] exp_req_q[$];
    rst_ev_t    exp_rst_q[$];
    bit         mon_en = 1'b0;

    adam_mem_pause_seq #(
        .NO_MEMS    (3),
        .SRST_CYCLES(16),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .srst_req     (srst_req),
        .mem_pause_req(mem_pause_req),
        .mem_pause_ack(mem_pause_ack),
        .mem_rst      (mem_rst),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: the ack follows the req one cycle later. Stuck memories never ack.
    always @(posedge clk) begin
        if (rst) mem_pause_ack <= 3'b000;
        else     mem_pause_ack <= mem_pause_req & ~stuck;
    end

    // Monitor: checks every req change and every mem_rst pulse against the scoreboard.
    initial begin
        logic [2:0] last_req, last_rst, e;
        int         rst_start[3];
        rst_ev_t    ev;
        last_req = 3'b000;
        last_rst = 3'b111;
        for (int i = 0; i < 3; i++) rst_start[i] = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                last_req = mem_pause_req;
                last_rst = mem_rst;
            end else begin
                if (mem_pause_req !== last_req) begin
                    n_tests++;
                    if (exp_req_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL req_seq: got %b, no change expected (cycle %0d)", mem_pause_req, cyc);
                    end else begin
                        e = exp_req_q.pop_front();
                        if (mem_pause_req !== e) begin
                            n_fail++;
                            $display("FAIL req_seq: got %b, expected %b (cycle %0d)", mem_pause_req, e, cyc);
                        end
                    end
                    last_req = mem_pause_req;
                end
                for (int i = 0; i < 3; i++) begin
                    if (mem_rst[i] && !last_rst[i]) begin
                        rst_start[i] = cyc;
                    end else if (!mem_rst[i] && last_rst[i]) begin
                        n_tests++;
                        if (exp_rst_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL rst_pulse: mem %0d pulse width %0d, no pulse expected", i, cyc - rst_start[i]);
                        end else begin
                            ev = exp_rst_q.pop_front();
                            if (ev.idx != i || ev.width != cyc - rst_start[i]) begin
                                n_fail++;
                                $display("FAIL rst_pulse: mem %0d width %0d, expected mem %0d width %0d",
                                         i, cyc - rst_start[i], ev.idx, ev.width);
                            end
                        end
                    end
                end
                last_rst = mem_rst;
            end
        end
    end

    task automatic push_req(input logic [2:0] v);
        exp_req_q.push_back(v);
    endtask

    task automatic push_rst(input int i, input int w);
        rst_ev_t ev;
        ev.idx   = i;
        ev.width = w;
        exp_rst_q.push_back(ev);
    endtask

    task automatic wait_pause_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (pause_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (busy === 1'b0 && exp_req_q.size() == 0 && exp_rst_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (mem_rst !== 3'b111) begin n_fail++; $display("FAIL reset_mem_rst: got %b, expected 111", mem_rst); end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", busy); end
        n_tests++;
        if (pause_ack !== 1'b0 || mem_pause_req !== 3'b000 || timeout_err !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b req=%b terr=%b, expected 0/000/000", pause_ack, mem_pause_req, timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_rst !== 3'b000) begin n_fail++; $display("FAIL init_mem_rst: got %b, expected 000", mem_rst); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b, expected 0", busy); end
        #5 mon_en = 1'b1;
    endtask

    task automatic test_pause();
        int c0;
        bit ok;
        push_req(3'b001); push_req(3'b011); push_req(3'b111);
        @(negedge clk);
        pause_req = 1'b1;
        c0 = cyc;
        wait_pause_ack(40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL pause_ack_wait: got no pause_ack, expected one within 40 cycles"); end
        n_tests++;
        if (cyc - c0 != 7) begin n_fail++; $display("FAIL pause_latency: got %0d cycles, expected 7", cyc - c0); end
        n_tests++;
        if (busy !== 1'b0 || mem_pause_req !== 3'b111) begin
            n_fail++;
            $display("FAIL paused_state: busy=%b req=%b, expected 0/111", busy, mem_pause_req);
        end
        push_req(3'b011); push_req(3'b001); push_req(3'b000);
        pause_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pause_ack !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ack: ack=%b busy=%b, expected 0/1", pause_ack, busy);
        end
        wait_idle(40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL resume_wait: still busy=%b or %0d reqs pending, expected idle", busy, exp_req_q.size()); end
    endtask

    task automatic test_soft_reset();
        bit ok;
        push_req(3'b010); push_req(3'b000); push_req(3'b100); push_req(3'b000);
        push_rst(1, 16); push_rst(2, 16);
        srst_req = 3'b110;
        @(negedge clk);
        srst_req = 3'b000;
        wait_idle(200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL srst_wait: busy=%b, %0d rst pulses outstanding, expected idle", busy, exp_rst_q.size()); end
        n_tests++;
        if (mem_rst !== 3'b000 || mem_pause_req !== 3'b000) begin
            n_fail++;
            $display("FAIL srst_end: rst=%b req=%b, expected 000/000", mem_rst, mem_pause_req);
        end
    endtask

    task automatic test_priority();
        bit ok;
        push_req(3'b001); push_req(3'b011); push_req(3'b111);
        push_req(3'b011); push_req(3'b001); push_req(3'b000);
        push_req(3'b001); push_req(3'b000);
        push_rst(0, 16);
        srst_req  = 3'b001;
        pause_req = 1'b1;
        @(negedge clk);
        srst_req = 3'b000;
        wait_pause_ack(40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL prio_pause: got no pause_ack, expected one within 40 cycles"); end
        n_tests++;
        if (mem_rst !== 3'b000) begin n_fail++; $display("FAIL prio_no_rst: rst=%b, expected 000 during pause", mem_rst); end
        pause_req = 1'b0;
        wait_idle(200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL prio_srst: busy=%b, %0d rst pulses outstanding, expected idle", busy, exp_rst_q.size()); end
    endtask

    task automatic test_timeout();
`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
        int c0;
        bit ok;
        stuck = 3'b010;
        push_req(3'b001); push_req(3'b011); push_req(3'b111);
        push_req(3'b011); push_req(3'b001); push_req(3'b000);
        @(negedge clk);
        pause_req = 1'b1;
        c0 = cyc;
        wait_pause_ack(60, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL tmo_pause: got no pause_ack, expected one after the timeout"); end
        n_tests++;
        if (cyc - c0 != 13) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles, expected 13", cyc - c0); end
        n_tests++;
        if (timeout_err !== 3'b010) begin n_fail++; $display("FAIL tmo_flag: got %b, expected 010", timeout_err); end
        pause_req = 1'b0;
        wait_idle(60, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL tmo_resume: busy=%b, expected idle", busy); end
        n_tests++;
        if (timeout_err !== 3'b010) begin n_fail++; $display("FAIL tmo_sticky: got %b, expected 010", timeout_err); end
        stuck = 3'b000;
`else
        n_tests++;
        if (timeout_err !== 3'b000) begin n_fail++; $display("FAIL tmo_tied: got %b, expected 000", timeout_err); end
`endif
    endtask

    task automatic test_rst_mid();
        int k;
        bit active;
        push_req(3'b001);
        srst_req = 3'b001;
        @(negedge clk);
        srst_req = 3'b000;
        k = 0;
        while (mem_rst[0] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (mem_rst[0] !== 1'b1) begin n_fail++; $display("FAIL mid_hold_wait: mem_rst=%b, expected bit 0 set", mem_rst); end
        // Counter is 15 here. Queue a second request, then stop when the counter reaches 5.
        srst_req = 3'b100;
        @(negedge clk);
        srst_req = 3'b000;
        repeat (9) @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_rst !== 3'b111 || mem_pause_req !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst: rst=%b req=%b busy=%b, expected 111/000/1", mem_rst, mem_pause_req, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_rst !== 3'b000) begin n_fail++; $display("FAIL mid_release: rst=%b, expected 000", mem_rst); end
        #5 mon_en = 1'b1;
        active = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || mem_pause_req !== 3'b000) active = 1'b1;
        end
        n_tests++;
        if (active) begin n_fail++; $display("FAIL mid_pending: sequencer became active, expected pending discarded"); end
    endtask

    initial begin
        test_reset();
        test_pause();
        test_soft_reset();
        test_priority();
        test_timeout();
        test_rst_mid();
        n_tests++;
        if (exp_req_q.size() != 0) begin n_fail++; $display("FAIL req_leftover: %0d transitions not seen, expected 0", exp_req_q.size()); end
        n_tests++;
        if (exp_rst_q.size() != 0) begin n_fail++; $display("FAIL rst_leftover: %0d pulses not seen, expected 0", exp_rst_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
